// File: rtl/trans_pkg.sv
// Shared transaction-word definitions for the deframer and validator.
package trans_pkg;

    localparam int unsigned TRANS_W         = 128;
    localparam int unsigned BYTES_PER_TRANS = 16;

    localparam int unsigned SENDER_MSB      = 127;
    localparam int unsigned SENDER_LSB      = 80;
    localparam int unsigned RECEIVER_MSB    = 79;
    localparam int unsigned RECEIVER_LSB    = 32;
    localparam int unsigned AMOUNT_MSB      = 31;
    localparam int unsigned AMOUNT_LSB      = 10;
    localparam int unsigned BIT_BLOCK_START = 9;

    typedef struct packed {
        logic [SENDER_MSB-SENDER_LSB:0]     sender;
        logic [RECEIVER_MSB-RECEIVER_LSB:0] receiver;
        logic [AMOUNT_MSB-AMOUNT_LSB:0]     amount;
        logic                               block_start;
        logic [BIT_BLOCK_START-1:0]         rsvd;
    } trans_t;

    typedef enum logic {StIdle, StAssemble} asm_state_e;

endpackage

// File: rtl/trans_fifo.sv
// Show-ahead synchronous FIFO; head entry is always visible on rdata.
module trans_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata;
                wptr_q                <= wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/trans_deframer.sv
// Assembles 16-byte frames into 128-bit transaction words and buffers them for the validator.
// Optional statistics counters are enabled with TRANS_DEFRAMER_STATS_EN.
module trans_deframer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   byte_i,
    input  logic         byte_valid_i,
    input  logic         sof_i,
    output logic [127:0] data_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [15:0]  frame_cnt_o,
    output logic [15:0]  drop_cnt_o
);

    import trans_pkg::*;

    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_TRANS - 1);

    asm_state_e           state_q, state_d;
    logic [3:0]           byte_cnt_q, byte_cnt_d;
    // Holds bytes 0..14; byte 15 is merged straight from the input on the push.
    logic [TRANS_W-9:0]   asm_q, asm_d;
    logic                 frame_done, resync;
    logic                 push, pop, drop, full, empty;
    trans_t               word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        frame_done = 1'b0;
        resync     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (byte_valid_i && sof_i) begin
                    asm_d      = {{(TRANS_W-16){1'b0}}, byte_i};
                    byte_cnt_d = 4'd1;
                    state_d    = StAssemble;
                end
            end
            StAssemble: begin
                if (byte_valid_i) begin
                    if (sof_i) begin
                        resync     = 1'b1;
                        asm_d      = {{(TRANS_W-16){1'b0}}, byte_i};
                        byte_cnt_d = 4'd1;
                    end else if (byte_cnt_q == LAST_BYTE) begin
                        frame_done = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = StIdle;
                    end else begin
                        asm_d      = {asm_q[TRANS_W-17:0], byte_i};
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign word    = trans_t'({asm_q, byte_i});
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign push    = frame_done && (!full || pop);
    assign drop    = resync || (frame_done && !push);

    trans_fifo #(
        .WIDTH (TRANS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (data_o),
        .full  (full),
        .empty (empty)
    );

`ifdef TRANS_DEFRAMER_STATS_EN
    logic [15:0] frame_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (push && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign frame_cnt_o = '0;
    assign drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_trans_deframer.sv
// Scoreboard bench for trans_deframer: expected words are queued as frames are driven.
module tb_trans_deframer;

    localparam int DEPTH = 4;
`ifdef TRANS_DEFRAMER_STATS_EN
    localparam logic [15:0] STAT_MASK = 16'hFFFF;
`else
    localparam logic [15:0] STAT_MASK = 16'h0000;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   byte_i;
    logic         byte_valid_i;
    logic         sof_i;
    logic [127:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic [15:0]  frame_cnt_o;
    logic [15:0]  drop_cnt_o;

    trans_deframer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .sof_i        (sof_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_cnt_o  (frame_cnt_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    logic [127:0] sb[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           exp_frames = 0;
    int           exp_drops = 0;
    int           cyc = 0;
    logic [127:0] last_data;
    logic         last_stall = 1'b0;
    logic [127:0] exp_w;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] exp_stat(input int v);
        return 16'(v) & STAT_MASK;
    endfunction

    function automatic logic [127:0] mkw(input int s);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[127-8*k -: 8] = 8'(s * 17 + k);
        return w;
    endfunction

    // Monitor: handshakes pop the scoreboard; stalled heads must hold still.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_stall = 1'b0;
        end else begin
            if (last_stall && valid_o) begin
                n_tests++;
                if (data_o !== last_data) begin
                    n_fail++;
                    $display("FAIL stable_data: got %h required %h", data_o, last_data);
                end
            end
            last_stall = valid_o && !ready_i;
            last_data  = data_o;
            if (valid_o && ready_i) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %h required none", data_o);
                end else begin
                    exp_w = sb.pop_front();
                    if (data_o !== exp_w) begin
                        n_fail++;
                        $display("FAIL word_order: got %h required %h", data_o, exp_w);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic sof);
        byte_i       = b;
        sof_i        = sof;
        byte_valid_i = 1'b1;
        @(posedge clk); #1;
        byte_valid_i = 1'b0;
        sof_i        = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [127:0] w, input int gap, input bit rdy_last);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                if (rdy_last) ready_i = 1'b1;
                if (sb.size() < DEPTH || (ready_i && sb.size() > 0)) begin
                    sb.push_back(w);
                    exp_frames++;
                end else begin
                    exp_drops++;
                end
            end
            send_byte(w[127-8*k -: 8], k == 0);
            if (k != 15) idle_cycles(gap);
        end
    endtask

    task automatic wait_drain(input string name);
        int i = 0;
        while (sb.size() != 0 && i < 200) begin @(posedge clk); #1; i++; end
        n_tests++;
        if (sb.size() != 0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending valid=%b required 0 pending valid=0",
                     name, sb.size(), valid_o);
        end
    endtask

    task automatic check_stats(input string name);
        n_tests++;
        if (frame_cnt_o !== exp_stat(exp_frames)) begin
            n_fail++;
            $display("FAIL %s_frame_cnt: got %0d required %0d", name, frame_cnt_o,
                     exp_stat(exp_frames));
        end
        n_tests++;
        if (drop_cnt_o !== exp_stat(exp_drops)) begin
            n_fail++;
            $display("FAIL %s_drop_cnt: got %0d required %0d", name, drop_cnt_o,
                     exp_stat(exp_drops));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; byte_i = '0; byte_valid_i = 1'b0; sof_i = 1'b0; ready_i = 1'b0;
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || data_o !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_out: got valid=%b data=%h required valid=0 data=0",
                     valid_o, data_o);
        end
        check_stats("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        ready_i = 1'b1;
        send_frame(128'h000102030405060708090A0B0C0D0E0F, 0, 1'b0);
        n_tests++;
        if (valid_o !== 1'b1 || data_o !== 128'h000102030405060708090A0B0C0D0E0F) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b data=%h required valid=1 data=%h",
                     valid_o, data_o, 128'h000102030405060708090A0B0C0D0E0F);
        end
        check_stats("single");
        wait_drain("single");
    endtask

    task automatic test_backpressure_overflow();
        ready_i = 1'b0;
        for (int f = 1; f <= 5; f++) send_frame(mkw(f), 0, 1'b0);
        check_stats("overflow");
        n_tests++;
        if (valid_o !== 1'b1 || data_o !== mkw(1)) begin
            n_fail++;
            $display("FAIL overflow_head: got valid=%b data=%h required valid=1 data=%h",
                     valid_o, data_o, mkw(1));
        end
        idle_cycles(3);
        ready_i = 1'b1;
        wait_drain("overflow");
    endtask

    task automatic test_resync();
        logic [127:0] a;
        a = mkw(7);
        ready_i = 1'b1;
        for (int k = 0; k < 7; k++) send_byte(a[127-8*k -: 8], k == 0);
        exp_drops++;
        send_frame(mkw(8), 0, 1'b0);
        check_stats("resync");
        wait_drain("resync");
    endtask

    task automatic test_stalls_garbage();
        int c0;
        ready_i = 1'b1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        c0 = cyc;
        send_frame(mkw(9), 1, 1'b0);
        n_tests++;
        if (cyc - c0 != 31 || valid_o !== 1'b1 || data_o !== mkw(9)) begin
            n_fail++;
            $display("FAIL stall_word: got cycles=%0d valid=%b data=%h required 31 1 %h",
                     cyc - c0, valid_o, data_o, mkw(9));
        end
        check_stats("stall");
        wait_drain("stall");
    endtask

    task automatic test_reset_midop();
        logic [127:0] p;
        ready_i = 1'b0;
        send_frame(mkw(10), 0, 1'b0);
        send_frame(mkw(11), 0, 1'b0);
        p = mkw(12);
        for (int k = 0; k < 9; k++) send_byte(p[127-8*k -: 8], k == 0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_frames = 0;
        exp_drops  = 0;
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset_valid: got %b required 0", valid_o);
        end
        check_stats("midop_reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b1;
        send_frame(mkw(13), 0, 1'b0);
        check_stats("midop_after");
        wait_drain("midop");
    endtask

    task automatic test_full_simultaneous_pop();
        int drops_before;
        ready_i = 1'b0;
        for (int f = 20; f < 24; f++) send_frame(mkw(f), 0, 1'b0);
        drops_before = exp_drops;
        send_frame(mkw(24), 0, 1'b1);
        ready_i = 1'b0;
        n_tests++;
        if (exp_drops != drops_before) begin
            n_fail++;
            $display("FAIL fullpop_model: got %0d drops required %0d", exp_drops, drops_before);
        end
        check_stats("fullpop");
        // FIFO must still be full: the next frame is dropped.
        send_frame(mkw(25), 0, 1'b0);
        check_stats("fullpop_full");
        ready_i = 1'b1;
        wait_drain("fullpop");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure_overflow();
        test_resync();
        test_stalls_garbage();
        test_reset_midop();
        test_full_simultaneous_pop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
